// File: rtl/store_align_buffer.sv
// Store alignment and write-buffer FIFO between the MEM stage and the data-memory write port.
// Also flags loads whose word address matches any queued store.
module store_align_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_st_valid,
  output logic                     o_st_ready,
  input  logic [31:0]              i_st_addr,
  input  logic [31:0]              i_st_data,
  input  logic [2:0]               i_st_funct3,
  output logic                     o_st_err,
  output logic                     o_dmem_valid,
  input  logic                     i_dmem_ready,
  output logic [31:0]              o_dmem_addr,
  output logic [31:0]              o_dmem_wdata,
  output logic [3:0]               o_dmem_mask,
  input  logic [31:0]              i_ld_addr,
  input  logic                     i_ld_valid,
  output logic                     o_ld_hazard,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [29:0]    r_addr  [DEPTH];
  logic [31:0]    r_wdata [DEPTH];
  logic [3:0]     r_mask  [DEPTH];
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic           r_st_err;

  logic [1:0]     w_off;
  logic [31:0]    w_wdata;
  logic [3:0]     w_mask;
  logic           w_err;
  logic           w_full;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic           w_hit;
  logic           w_unused_ld_off;

  assign w_off = i_st_addr[1:0];

  always_comb begin
    w_wdata = '0;
    w_mask  = '0;
    w_err   = 1'b0;
    case (i_st_funct3)
      3'b000: begin
        w_wdata = {4{i_st_data[7:0]}};
        w_mask  = 4'b0001 << w_off;
      end
      3'b001: begin
        w_wdata = {2{i_st_data[15:0]}};
        w_mask  = w_off[1] ? 4'b1100 : 4'b0011;
        w_err   = w_off[0];
      end
      3'b010: begin
        w_wdata = i_st_data;
        w_mask  = '1;
        w_err   = (w_off != 2'b00);
      end
      default: w_err = 1'b1;
    endcase
  end

  // No full-bypass: a pop in the same cycle does not open a slot.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_accept = i_st_valid && !w_full;
  assign w_push   = w_accept && !w_err;
  assign w_pop    = (r_count != '0) && i_dmem_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_st_err <= 1'b0;
    end else begin
      r_st_err <= w_accept && w_err;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr[r_tail]  <= i_st_addr[31:2];
      r_wdata[r_tail] <= w_wdata;
      r_mask[r_tail]  <= w_mask;
    end
  end

  // Walk occupied slots from the head so stale entries past the count never match.
  always_comb begin
    w_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (r_addr[r_head + AW'(i)] == i_ld_addr[31:2]))
        w_hit = 1'b1;
    end
  end

  assign w_unused_ld_off = ^i_ld_addr[1:0];

  assign o_st_ready   = !w_full;
  assign o_st_err     = r_st_err;
  assign o_dmem_valid = (r_count != '0);
  assign o_dmem_addr  = {r_addr[r_head], 2'b00};
  assign o_dmem_wdata = r_wdata[r_head];
  assign o_dmem_mask  = r_mask[r_head];
  assign o_ld_hazard  = i_ld_valid && w_hit;
  assign o_count      = r_count;

endmodule
